temp_avg_filter: RTL
====================

Name: temp_avg_filter

Overview:
- Sample conditioner between the I2C temperature sensor controller and the temperature-to-digit converter.
- Captures each new 13-bit two's-complement reading (4 fractional bits, 0.0625 °C/LSB) on the controller's ready strobe and discards readings flagged with an error.
- Outputs a boxcar moving average over the last DEPTH good samples, so the seven-segment display does not flicker on LSB noise.
- Also flags sticky errors and a stale-data timeout.

Parameters:
- LOG2_DEPTH, 3, log2 of averaging window; DEPTH = 2**LOG2_DEPTH (8).
- STALE_CYCLES, 100_000_000, clocks without an accepted sample before stale asserts (1 s at 100 MHz).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- tmp_rdy  input  1  ready level from the sensor controller; a new sample is signalled by its rising edge.
- tmp_err  input  1  error flag from the sensor controller.
- temp_in  input  13  raw signed temperature, 4 fractional bits.
- temp_out  output  13  signed averaged temperature, same format.
- valid  output  1  high once at least one good sample has been accepted.
- updated  output  1  one-clock pulse when temp_out changes value source (new average loaded).
- err_sticky  output  1  set when a sample is discarded due to tmp_err; cleared only by rst.
- stale  output  1  no accepted sample for STALE_CYCLES clocks.

Behaviour:
- Reset (synchronous, rst high at a clk edge):
  - temp_out=0, valid=0, updated=0, err_sticky=0, stale=0.
  - rdy_d=0, sum=0, write pointer=0, stale counter=0, state=EMPTY.
  - Buffer contents are don't-care.
- Edge detect:
  - rdy_d registers tmp_rdy every clock.
  - edge = tmp_rdy & ~rdy_d, evaluated combinationally at the clock edge.
  - Level held high produces exactly one edge.
- Accept rule: edge & ~tmp_err accepts temp_in. edge & tmp_err discards the sample, sets err_sticky and touches no other state.
- State EMPTY, on accept:
  - Every buffer entry is written with temp_in.
  - sum = temp_in sign-extended × DEPTH, i.e. shifted left LOG2_DEPTH.
  - Write pointer = 1.
  - Transition to RUN.
  - No averaging transient at power-up.
- State RUN, on accept:
  - sum = sum − buf[ptr] + temp_in.
  - buf[ptr] = temp_in.
  - ptr = ptr+1 modulo DEPTH (natural wrap, LOG2_DEPTH bits).
- Arithmetic:
  - sum is signed, 13+LOG2_DEPTH bits; cannot overflow.
  - Average = sum >>> LOG2_DEPTH (arithmetic shift, floor toward −∞), truncated to 13 bits (always fits).
- Latency:
  - Accept at clock k updates sum/buffer at k.
  - At clock k+1: temp_out loads the new average, updated=1, valid=1.
  - updated returns to 0 at k+2 unless another accept occurred at k+1.
  - Back-to-back edges are impossible (need a low cycle in between), so the pipeline never stalls.
- valid: stays 1 after the first accept until rst; a discarded sample never clears it.
- Stale:
  - Counter clears on each accept.
  - Otherwise it increments, saturating at STALE_CYCLES.
  - stale = (counter == STALE_CYCLES), registered.
  - Cleared on the clock after the next accept.
  - Discarded samples do not clear it.
  - Counter runs in EMPTY too, so a dead sensor after reset asserts stale.
- Reset mid-operation:
  - rst overrides everything in the same cycle.
  - An edge coincident with rst is ignored.
  - rdy_d is cleared, so a tmp_rdy still high after rst release produces a fresh edge and is accepted.
- No FC dependence: conversion to °F stays in the downstream converter.

Test Plan:
- Reset, then tmp_rdy 0→1 with temp_in=13'h191 (25.0625 °C) -> two clocks later temp_out=13'h191, valid=1, updated pulses one clock, err_sticky=0.
- After prefill with 400 (25.0 °C), one accepted sample of 480 -> sum=3280, temp_out=410; seven more samples of 480 -> temp_out=480; ninth sample 400 -> temp_out=470 (pointer wrap verified).
- Prefill −160 (13'h1F60, −10.0 °C), then sample −161 (13'h1F5F) -> temp_out=−161 (13'h1F5F), confirming floor rounding.
- Edge with tmp_err=1 and temp_in=13'h0FFF -> temp_out, sum and valid unchanged, err_sticky=1 until rst; next clean edge is accepted normally.
- STALE_CYCLES overridden to 20, one accept, then no edges -> stale=1 after 20 clocks; next accept -> stale=0 the following clock.
- tmp_rdy held high across rst assertion and release -> one accept the clock after release, none before; no repeated accepts while the level stays high.

Source files
------------

// File: rtl/temp_avg_filter.sv
// Boxcar moving-average conditioner for the I2C temperature sensor path.
// Accepts clean samples on the tmp_rdy rising edge and flags sticky errors and stale data.
module temp_avg_filter #(
    parameter int LOG2_DEPTH   = 3,
    parameter int STALE_CYCLES = 100_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tmp_rdy,
    input  logic        tmp_err,
    input  logic [12:0] temp_in,
    output logic [12:0] temp_out,
    output logic        valid,
    output logic        updated,
    output logic        err_sticky,
    output logic        stale
);

    localparam int DEPTH = 1 << LOG2_DEPTH;
    localparam int SW    = 13 + LOG2_DEPTH;
    localparam int CW    = $clog2(STALE_CYCLES + 1);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    rdy_q;
    logic [LOG2_DEPTH-1:0]   ptr_q, ptr_d;
    logic signed [SW-1:0]    sum_q, sum_d;
    logic [12:0]             buf_q [DEPTH];
    logic                    pend_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [12:0]             temp_out_q;
    logic                    valid_q;
    logic                    updated_q;
    logic                    err_q;
    logic                    stale_q;

    logic                    edge_s;
    logic                    accept_s;
    logic                    discard_s;
    logic signed [SW-1:0]    new_ext_s;
    logic signed [SW-1:0]    old_ext_s;
    logic signed [SW-1:0]    avg_full_s;
    logic [12:0]             avg_s;

    // Edge detect, sign extension and next-state for the running sum, pointer and stale counter
    always_comb begin
        edge_s     = tmp_rdy & ~rdy_q;
        accept_s   = edge_s & ~tmp_err;
        discard_s  = edge_s & tmp_err;
        new_ext_s  = {{LOG2_DEPTH{temp_in[12]}}, temp_in};
        old_ext_s  = {{LOG2_DEPTH{buf_q[ptr_q][12]}}, buf_q[ptr_q]};
        avg_full_s = sum_q >>> LOG2_DEPTH;
        avg_s      = avg_full_s[12:0];
        sum_d      = sum_q;
        ptr_d      = ptr_q;
        state_d    = state_q;
        if (accept_s) begin
            case (state_q)
                ST_EMPTY: begin
                    // Prefill the whole window so the first output is the sample itself
                    sum_d   = new_ext_s <<< LOG2_DEPTH;
                    ptr_d   = LOG2_DEPTH'(1);
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    sum_d   = sum_q - old_ext_s + new_ext_s;
                    ptr_d   = ptr_q + LOG2_DEPTH'(1);
                    state_d = ST_RUN;
                end
                default: begin
                    sum_d   = sum_q;
                    ptr_d   = ptr_q;
                    state_d = ST_EMPTY;
                end
            endcase
        end else begin
            sum_d   = sum_q;
            ptr_d   = ptr_q;
            state_d = state_q;
        end
        if (accept_s) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(STALE_CYCLES)) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Sample window storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (!rst && accept_s) begin
            if (state_q == ST_EMPTY) begin
                for (int i = 0; i < DEPTH; i++) begin
                    buf_q[i] <= temp_in;
                end
            end else begin
                buf_q[ptr_q] <= temp_in;
            end
        end
    end

    // Control state, sum, and registered outputs (average loads one clock after accept)
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rdy_q      <= 1'b0;
            ptr_q      <= '0;
            sum_q      <= '0;
            pend_q     <= 1'b0;
            cnt_q      <= '0;
            temp_out_q <= 13'd0;
            valid_q    <= 1'b0;
            updated_q  <= 1'b0;
            err_q      <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rdy_q     <= tmp_rdy;
            ptr_q     <= ptr_d;
            sum_q     <= sum_d;
            pend_q    <= accept_s;
            cnt_q     <= cnt_d;
            updated_q <= pend_q;
            err_q     <= err_q | discard_s;
            stale_q   <= (cnt_q == CW'(STALE_CYCLES));
            if (pend_q) begin
                temp_out_q <= avg_s;
                valid_q    <= 1'b1;
            end else begin
                temp_out_q <= temp_out_q;
                valid_q    <= valid_q;
            end
        end
    end

    assign temp_out   = temp_out_q;
    assign valid      = valid_q;
    assign updated    = updated_q;
    assign err_sticky = err_q;
    assign stale      = stale_q;

endmodule
